fb_line_reader: RTL and testbench

FB_LINE_READER -- requirements
Module: fb_line_reader

---
 rtl/fb_line_reader.sv | 193 +++++++++++++++++++
 tb/tb_fb_line_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_line_reader.sv
// Framebuffer row fetcher: streams one framebuffer row per FB_SCALE display lines into a linebuffer.
// Optional macro FB_LINE_READER_STATS_EN enables the saturating overrun counter.
module fb_line_reader #(
  parameter int unsigned ADDRW     = 16,
  parameter int unsigned DATAW     = 4,
  parameter int unsigned FB_WIDTH  = 320,
  parameter int unsigned FB_HEIGHT = 180,
  parameter int unsigned FB_SCALE  = 2,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame,
  input  logic             line,
  input  logic             line0,
  output logic [ADDRW-1:0] fb_addr,
  output logic             fb_re,
  input  logic [DATAW-1:0] fb_data,
  output logic             lb_valid,
  output logic [DATAW-1:0] lb_data,
  output logic             busy,
  output logic             overrun,
  output logic [15:0]      overrun_cnt
);

  localparam int unsigned COLW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int unsigned ROWW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
  localparam int unsigned SCW  = 6;
  localparam int unsigned DRW  = 2;

  typedef enum logic [1:0] {IDLE, WAIT, READ, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] fb_addr_q, fb_addr_d;
  logic [ADDRW-1:0] base_q, base_d;
  logic             fb_re_q, fb_re_d;
  logic [COLW-1:0]  col_q, col_d;
  logic [ROWW-1:0]  row_q, row_d;
  logic [SCW-1:0]   scale_q, scale_d;
  logic [DRW-1:0]   drain_q, drain_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [RD_LAT:0]  re_pipe_q;
  logic [DATAW-1:0] lb_data_q;
  logic             adv;

  // State and fetch-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fb_addr_q <= '0;
      base_q    <= '0;
      fb_re_q   <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      scale_q   <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fb_addr_q <= fb_addr_d;
      base_q    <= base_d;
      fb_re_q   <= fb_re_d;
      col_q     <= col_d;
      row_q     <= row_d;
      scale_q   <= scale_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic; a line pulse outside IDLE always advances the scale/row position
  always_comb begin
    state_d   = state_q;
    fb_addr_d = fb_addr_q;
    base_d    = base_q;
    fb_re_d   = 1'b0;
    col_d     = col_q;
    row_d     = row_q;
    scale_d   = scale_q;
    drain_d   = drain_q;
    overrun_d = 1'b0;
    adv       = 1'b0;

    if (frame) begin
      state_d = IDLE;
    end else if (line0) begin
      state_d   = READ;
      fb_addr_d = '0;
      base_d    = '0;
      col_d     = '0;
      row_d     = '0;
      scale_d   = '0;
      fb_re_d   = 1'b1;
    end else begin
      case (state_q)
        READ: begin
          if (line) begin
            overrun_d = 1'b1;
            adv       = 1'b1;
          end else begin
            fb_addr_d = fb_addr_q + ADDRW'(1);
            col_d     = col_q + COLW'(1);
            if (col_q == COLW'(FB_WIDTH - 1)) begin
              state_d = DRAIN;
              drain_d = '0;
            end else begin
              fb_re_d = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (line) begin
            overrun_d = 1'b1;
            adv       = 1'b1;
          end else if (drain_q == DRW'(RD_LAT - 1)) begin
            state_d = WAIT;
          end else begin
            drain_d = drain_q + DRW'(1);
          end
        end
        WAIT: begin
          adv = line;
        end
        default: ;
      endcase

      // Re-align to the next row start so truncated rows never shift the image
      if (adv) begin
        fb_addr_d = base_q + ADDRW'(FB_WIDTH);
        fb_re_d   = 1'b0;
        if (row_q == ROWW'(FB_HEIGHT - 1) && scale_q == SCW'(FB_SCALE - 1)) begin
          state_d = IDLE;
        end else if (scale_q == SCW'(FB_SCALE - 1)) begin
          scale_d = '0;
          row_d   = row_q + ROWW'(1);
          base_d  = base_q + ADDRW'(FB_WIDTH);
          col_d   = '0;
          state_d = READ;
          fb_re_d = 1'b1;
        end else begin
          scale_d = scale_q + SCW'(1);
          state_d = WAIT;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  // Read-return pipeline; frame discards anything still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_pipe_q <= '0;
      lb_data_q <= '0;
    end else begin
      if (frame) begin
        re_pipe_q <= '0;
      end else begin
        re_pipe_q <= {re_pipe_q[RD_LAT-1:0], fb_re_q};
      end
      if (re_pipe_q[RD_LAT-1]) begin
        lb_data_q <= fb_data;
      end
    end
  end

`ifdef FB_LINE_READER_STATS_EN
  logic [15:0] ovr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt_q <= '0;
    end else if (overrun_q && ovr_cnt_q != 16'hFFFF) begin
      ovr_cnt_q <= ovr_cnt_q + 16'd1;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`else
  assign overrun_cnt = 16'h0;
`endif

  assign fb_addr  = fb_addr_q;
  assign fb_re    = fb_re_q;
  assign lb_valid = re_pipe_q[RD_LAT];
  assign lb_data  = lb_data_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_fb_line_reader.sv
// Directed bench for fb_line_reader on a 4x3 framebuffer, scale 2, read latency 1.
module tb_fb_line_reader;

  logic        clk;
  logic        rst_n;
  logic        frame;
  logic        line;
  logic        line0;
  logic [15:0] fb_addr;
  logic        fb_re;
  logic [3:0]  fb_data;
  logic        lb_valid;
  logic [3:0]  lb_data;
  logic        busy;
  logic        overrun;
  logic [15:0] overrun_cnt;

  int total = 0;
  int bad   = 0;

  int          line_idx   = 0;
  int          rd_cnt [64];
  int          ovr_pulses = 0;
  logic [15:0] addr_q [$];
  logic [3:0]  lbd_q  [$];

  fb_line_reader #(
    .ADDRW(16), .DATAW(4), .FB_WIDTH(4), .FB_HEIGHT(3), .FB_SCALE(2), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .line(line), .line0(line0),
    .fb_addr(fb_addr), .fb_re(fb_re), .fb_data(fb_data),
    .lb_valid(lb_valid), .lb_data(lb_data), .busy(busy),
    .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer model: one-cycle read latency, content equals low address bits
  always @(posedge clk) fb_data <= fb_addr[3:0];

  always @(negedge clk) begin
    if (fb_re) begin
      addr_q.push_back(fb_addr);
      if (line_idx < 64) rd_cnt[line_idx] = rd_cnt[line_idx] + 1;
    end
    if (lb_valid) lbd_q.push_back(lb_data);
    if (overrun) ovr_pulses = ovr_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_line(input logic l0);
    line_idx = line_idx + 1;
    line  = 1'b1;
    line0 = l0;
    tick(1);
    line  = 1'b0;
    line0 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  int a0, l0s, lstart, o0, a1, l1;
  logic [15:0] ovr_exp;

  initial begin
    rst_n = 1'b0; frame = 1'b0; line = 1'b0; line0 = 1'b0;
    tick(3);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_re", 32'(fb_re), 0);
    chk("rst_lbv", 32'(lb_valid), 0);
    chk("rst_lbd", 32'(lb_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_ocnt", 32'(overrun_cnt), 0);
    rst_n = 1'b1;
    tick(2);

    // First row timing, then the rest of a full frame with lines 20 cycles apart
    a0 = addr_q.size(); l0s = lbd_q.size(); lstart = line_idx;
    send_line(1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("r0_re%0d", i), 32'(fb_re), (i < 4) ? 1 : 0);
      if (i < 4) chk($sformatf("r0_addr%0d", i), 32'(fb_addr), 32'(i));
      chk($sformatf("r0_lbv%0d", i), 32'(lb_valid), (i >= 2 && i < 6) ? 1 : 0);
      if (i >= 2 && i < 6) chk($sformatf("r0_lbd%0d", i), 32'(lb_data), 32'(i - 2));
      @(posedge clk);
      #1;
    end
    tick(12);
    for (int k = 1; k <= 5; k++) begin
      send_line(1'b0);
      tick(19);
    end
    chk("ff_busy_l5", 32'(busy), 1);
    send_line(1'b0);
    chk("ff_busy_end", 32'(busy), 0);
    tick(19);
    send_line(1'b0);
    tick(5);
    for (int k = 0; k < 8; k++)
      chk($sformatf("ff_reads_line%0d", k), 32'(rd_cnt[lstart + 1 + k]),
          (k == 0 || k == 2 || k == 4) ? 4 : 0);
    chk("ff_naddr", 32'(addr_q.size() - a0), 12);
    chk("ff_nlb", 32'(lbd_q.size() - l0s), 12);
    for (int k = 0; k < 12; k++) begin
      if (a0 + k < addr_q.size()) chk($sformatf("ff_addr%0d", k), 32'(addr_q[a0 + k]), 32'(k));
      if (l0s + k < lbd_q.size()) chk($sformatf("ff_lbd%0d", k), 32'(lbd_q[l0s + k]), 32'(k));
    end

    // Lines 2 cycles apart: every row truncated to 2 pixels, rows stay aligned
    do_reset();
    a0 = addr_q.size(); l0s = lbd_q.size(); o0 = ovr_pulses;
    send_line(1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      send_line(1'b0);
    end
    chk("ov_busy_end", 32'(busy), 0);
    tick(4);
    chk("ov_pulses", 32'(ovr_pulses - o0), 3);
`ifdef FB_LINE_READER_STATS_EN
    ovr_exp = 16'd3;
`else
    ovr_exp = 16'd0;
`endif
    chk("ov_cnt", 32'(overrun_cnt), 32'(ovr_exp));
    chk("ov_naddr", 32'(addr_q.size() - a0), 6);
    chk("ov_nlb", 32'(lbd_q.size() - l0s), 6);
    begin
      int exp_a [6] = '{0, 1, 4, 5, 8, 9};
      for (int k = 0; k < 6; k++) begin
        if (a0 + k < addr_q.size()) chk($sformatf("ov_addr%0d", k), 32'(addr_q[a0 + k]), 32'(exp_a[k]));
        if (l0s + k < lbd_q.size()) chk($sformatf("ov_lbd%0d", k), 32'(lbd_q[l0s + k]), 32'(exp_a[k] & 15));
      end
    end

    // frame mid-row aborts fetch and flushes the return pipeline
    do_reset();
    send_line(1'b1);
    tick(2);
    chk("fr_pre_addr", 32'(fb_addr), 2);
    chk("fr_pre_re", 32'(fb_re), 1);
    frame = 1'b1;
    tick(1);
    frame = 1'b0;
    chk("fr_re", 32'(fb_re), 0);
    chk("fr_lbv", 32'(lb_valid), 0);
    chk("fr_busy", 32'(busy), 0);
    @(negedge clk);
    a1 = addr_q.size(); l1 = lbd_q.size();
    @(posedge clk);
    #1;
    tick(10);
    chk("fr_no_reads", 32'(addr_q.size() - a1), 0);
    chk("fr_no_lb", 32'(lbd_q.size() - l1), 0);

    // Asynchronous reset in the middle of a row fetch
    do_reset();
    send_line(1'b1);
    tick(1);
    chk("ar_pre_re", 32'(fb_re), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_re", 32'(fb_re), 0);
    chk("ar_addr", 32'(fb_addr), 0);
    chk("ar_lbv", 32'(lb_valid), 0);
    chk("ar_lbd", 32'(lb_data), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_ocnt", 32'(overrun_cnt), 0);
    tick(3);
    rst_n = 1'b1;
    a1 = addr_q.size(); l1 = lbd_q.size();
    tick(10);
    chk("ar_idle_reads", 32'(addr_q.size() - a1), 0);
    chk("ar_idle_lb", 32'(lbd_q.size() - l1), 0);
    send_line(1'b1);
    chk("ar_resume_re", 32'(fb_re), 1);
    chk("ar_resume_addr", 32'(fb_addr), 0);
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
